// File: rtl/marshal_pkg.sv
// Shared types and default sizes for the serial-to-parallel marshalling arbiter.
package marshal_pkg;

  localparam int NUM_LANES_DEF = 4;
  localparam int BYTE_W_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer,
// wrapping from NUM_LANES-1 back to 0.
module rr_arbiter #(
  parameter  int NUM_LANES = 4,
  localparam int LANE_W    = $clog2(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] i_req,
  input  logic [LANE_W-1:0]    i_ptr,
  output logic [NUM_LANES-1:0] o_gnt,
  output logic [LANE_W-1:0]    o_idx,
  output logic                 o_any
);

  logic [LANE_W:0]   w_sum;
  logic [LANE_W-1:0] w_k;

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_sum = '0;
    w_k   = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      w_sum = {1'b0, i_ptr} + (LANE_W+1)'(i);
      if (w_sum >= (LANE_W+1)'(NUM_LANES)) begin
        w_sum = w_sum - (LANE_W+1)'(NUM_LANES);
      end
      w_k = w_sum[LANE_W-1:0];
      if (i_req[w_k]) begin
        o_gnt      = '0;
        o_gnt[w_k] = 1'b1;
        o_idx      = w_k;
        o_any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sreg_marshal_arbiter.sv
// Round-robin owner of a shared serial-to-parallel shift register: grants one
// lane for BYTE_W bit-times, assembles its byte LSB-first and hands it out on
// a valid/ready port tagged with the source lane.
module sreg_marshal_arbiter
  import marshal_pkg::*;
#(
  parameter  int NUM_LANES = NUM_LANES_DEF,
  parameter  int BYTE_W    = BYTE_W_DEF,
  localparam int LANE_W    = $clog2(NUM_LANES),
  localparam int CNT_W     = $clog2(BYTE_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] lane_req,
  input  logic [NUM_LANES-1:0] lane_sdata,
  output logic [NUM_LANES-1:0] lane_gnt,
  output logic [BYTE_W-1:0]    out_data,
  output logic [LANE_W-1:0]    out_lane,
  output logic                 out_valid,
  input  logic                 out_ready
);

  state_t                r_state;
  state_t                w_next;
  logic [LANE_W-1:0]     r_cur_lane;
  logic [LANE_W-1:0]     r_ptr;
  logic [CNT_W-1:0]      r_cnt;
  logic [BYTE_W-1:0]     r_shreg;
  logic [NUM_LANES-1:0]  r_gnt;
  logic [BYTE_W-1:0]     r_out_data;
  logic [LANE_W-1:0]     r_out_lane;
  logic                  r_out_valid;

  logic [NUM_LANES-1:0]  w_arb_gnt;
  logic [LANE_W-1:0]     w_arb_idx;
  logic                  w_arb_any;
  logic                  w_last_bit;
  logic                  w_slot_free;
  logic [LANE_W-1:0]     w_ptr_next;

  rr_arbiter #(
    .NUM_LANES (NUM_LANES)
  ) u_arb (
    .i_req (lane_req),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx),
    .o_any (w_arb_any)
  );

  assign w_last_bit  = (r_cnt == CNT_W'(BYTE_W - 1));
  assign w_slot_free = !r_out_valid || out_ready;
  // Explicit wrap so non-power-of-two lane counts step correctly.
  assign w_ptr_next  = (r_cur_lane == LANE_W'(NUM_LANES - 1)) ? '0
                                                               : r_cur_lane + LANE_W'(1);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state: arbitrate when idle, shift BYTE_W bits, then wait for a free output slot.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_arb_any)   w_next = SHIFT;
      SHIFT:   if (w_last_bit)  w_next = DONE;
      DONE:    if (w_slot_free) w_next = IDLE;
      default:                  w_next = IDLE;
    endcase
  end

  // Grant, bit counter, shift register and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cur_lane <= '0;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_shreg    <= '0;
      r_gnt      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_arb_any) begin
            r_cur_lane <= w_arb_idx;
            r_gnt      <= w_arb_gnt;
            r_cnt      <= '0;
          end
        end
        SHIFT: begin
          r_shreg <= {lane_sdata[r_cur_lane], r_shreg[BYTE_W-1:1]};
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last_bit) r_gnt <= '0;
        end
        DONE: begin
          if (w_slot_free) r_ptr <= w_ptr_next;
        end
        default: r_gnt <= '0;
      endcase
    end
  end

  // Output holding register: load from DONE when free, otherwise clear on acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_data  <= '0;
      r_out_lane  <= '0;
      r_out_valid <= 1'b0;
    end else if (r_state == DONE && w_slot_free) begin
      r_out_data  <= r_shreg;
      r_out_lane  <= r_cur_lane;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign lane_gnt  = r_gnt;
  assign out_data  = r_out_data;
  assign out_lane  = r_out_lane;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_sreg_marshal_arbiter.sv
// Self-checking bench for sreg_marshal_arbiter: per-lane serial senders driven
// from byte queues, a transaction-level round-robin model and an output scoreboard.
module tb_sreg_marshal_arbiter;

  localparam int NL = 4;
  localparam int BW = 8;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NL-1:0] lane_req;
  logic [NL-1:0] lane_sdata;
  logic [NL-1:0] lane_gnt;
  logic [BW-1:0] out_data;
  logic [LW-1:0] out_lane;
  logic          out_valid;
  logic          out_ready;

  sreg_marshal_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .lane_req   (lane_req),
    .lane_sdata (lane_sdata),
    .lane_gnt   (lane_gnt),
    .out_data   (out_data),
    .out_lane   (out_lane),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         lane;
    logic [7:0] data;
  } item_t;

  typedef struct {
    int         lane;
    logic [7:0] data;
    int         exp_lane;
    logic [7:0] exp_data;
    int         exp_lat;
  } vec_t;

  int         total = 0;
  int         bad   = 0;
  item_t      exp_q[$];
  logic [7:0] lq[NL][$];
  logic [7:0] cur_b[NL];
  int         pos[NL];
  int         run[NL];
  int         model_ptr = 0;
  int         acc_cyc[$];
  bit         rdy_rand = 0;
  logic       rdy_fix  = 1'b1;
  bit         pend     = 0;
  logic [7:0] pend_d;
  logic [LW-1:0] pend_l;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push_byte(input int l, input logic [7:0] b);
    lq[l].push_back(b);
  endtask

  // Reference: every queued byte is requested at once; each decision takes the
  // first lane with bytes left at or after the pointer, then the pointer moves past it.
  task automatic model_batch();
    int rem[NL];
    int idx[NL];
    int left;
    int l;
    left = 0;
    for (int k = 0; k < NL; k++) begin
      rem[k] = lq[k].size();
      idx[k] = 0;
      left  += rem[k];
    end
    while (left > 0) begin
      l = 0;
      for (int i = 0; i < NL; i++) begin
        l = (model_ptr + i) % NL;
        if (rem[l] > 0) break;
      end
      exp_q.push_back('{l, lq[l][idx[l]]});
      idx[l]++;
      rem[l]--;
      left--;
      model_ptr = (l + 1) % NL;
    end
  endtask

  task automatic tb_clear();
    for (int k = 0; k < NL; k++) begin
      lq[k].delete();
      pos[k]   = 0;
      run[k]   = 0;
      cur_b[k] = 8'h00;
    end
    lane_req  = '0;
    exp_q.delete();
    pend      = 0;
    model_ptr = 0;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || lane_gnt != '0 || out_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      total++;
      bad++;
      $display("FAIL drain_%s: waited %0d cycles, %0d outputs outstanding, want 0", nm, n, exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm, output int waited);
    waited = 0;
    while (!out_valid && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (!out_valid) begin
      total++;
      bad++;
      $display("FAIL valid_%s: out_valid still 0 after %0d cycles, want 1", nm, waited);
    end
  endtask

  // Lane senders and output scoreboard, all evaluated on the falling edge.
  initial begin
    item_t e;
    lane_req   = '0;
    lane_sdata = '0;
    out_ready  = 1'b1;
    forever begin
      @(negedge clk);
      out_ready = rdy_rand ? 1'($urandom) : rdy_fix;
      if (rst) begin
        chk("gnt_onehot", 32'($onehot0(lane_gnt)), 32'd1);
        for (int l = 0; l < NL; l++) begin
          if (lane_gnt[l]) begin
            if (pos[l] == 0) begin
              if (lq[l].size() > 0) begin
                cur_b[l] = lq[l].pop_front();
              end else begin
                cur_b[l] = 8'h00;
                total++;
                bad++;
                $display("FAIL gnt_unrequested: lane %0d gnt got 1 want 0", l);
              end
            end
            lane_sdata[l] = cur_b[l][pos[l][2:0]];
            pos[l] = (pos[l] == BW - 1) ? 0 : pos[l] + 1;
            run[l]++;
          end else begin
            lane_sdata[l] = 1'($urandom);
            if (run[l] != 0) begin
              chk($sformatf("gnt_len_l%0d", l), run[l], BW);
              run[l] = 0;
            end
          end
          lane_req[l] = (lq[l].size() != 0);
        end
        if (pend) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_data", 32'(out_data), 32'(pend_d));
          chk("hold_lane", 32'(out_lane), 32'(pend_l));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got lane %0d data %0h want no output", out_lane, out_data);
          end else begin
            e = exp_q.pop_front();
            chk("out_lane", 32'(out_lane), e.lane);
            chk("out_data", 32'(out_data), 32'(e.data));
          end
          acc_cyc.push_back(cyc);
          pend = 0;
        end else begin
          pend   = out_valid;
          pend_d = out_data;
          pend_l = out_lane;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t, want finish before 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl[5];
    item_t e1, e2;
    int    c0, w;

    tbl[0] = '{0, 8'hA5, 0, 8'hA5, BW + 2};
    tbl[1] = '{2, 8'h3C, 2, 8'h3C, BW + 2};
    tbl[2] = '{1, 8'h00, 1, 8'h00, BW + 2};
    tbl[3] = '{0, 8'hFF, 0, 8'hFF, BW + 2};
    tbl[4] = '{3, 8'h81, 3, 8'h81, BW + 2};

    // Reset state
    #1 rst = 1'b0;
    tb_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(lane_gnt), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_lane", 32'(out_lane), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;

    // Single-lane vectors: latency, data and lane
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      push_byte(tbl[i].lane, tbl[i].data);
      model_batch();
      @(negedge clk);
      c0 = cyc;
      wait_valid($sformatf("vec%0d", i), w);
      chk($sformatf("vec%0d_lat", i), cyc - c0, tbl[i].exp_lat);
      chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(tbl[i].exp_data));
      chk($sformatf("vec%0d_lane", i), 32'(out_lane), tbl[i].exp_lane);
      wait_drain($sformatf("vec%0d", i));
    end

    // Lanes 0 and 2 together
    @(posedge clk);
    #1;
    push_byte(0, 8'h3C);
    push_byte(2, 8'hC3);
    model_batch();
    wait_drain("pair");

    // Bring pointer to 0, then all lanes requesting continuously
    push_byte(3, 8'h55);
    model_batch();
    wait_drain("ptr0");
    acc_cyc.delete();
    push_byte(0, 8'h10);
    push_byte(0, 8'h20);
    push_byte(1, 8'h11);
    push_byte(1, 8'h21);
    push_byte(2, 8'h12);
    push_byte(3, 8'h13);
    model_batch();
    wait_drain("all4");
    chk("all4_count", acc_cyc.size(), 6);
    for (int i = 1; i < acc_cyc.size(); i++) begin
      chk($sformatf("all4_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], BW + 2);
    end

    // Backpressure: first byte held, second parked in DONE
    rdy_fix = 1'b0;
    push_byte(1, 8'h96);
    push_byte(2, 8'h69);
    model_batch();
    e1 = exp_q[0];
    e2 = exp_q[1];
    wait_valid("bp", w);
    repeat (25) @(negedge clk);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_data1", 32'(out_data), 32'(e1.data));
    chk("bp_lane1", 32'(out_lane), e1.lane);
    chk("bp_gnt", 32'(lane_gnt), 32'd0);
    @(posedge clk);
    #1 rdy_fix = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_valid2", 32'(out_valid), 32'd1);
    chk("bp_data2", 32'(out_data), 32'(e2.data));
    chk("bp_lane2", 32'(out_lane), e2.lane);
    wait_drain("bp");

    // Asynchronous reset in the middle of a capture
    push_byte(1, 8'h44);
    model_batch();
    wait_drain("pre_rst");
    push_byte(1, 8'h5A);
    w = 0;
    while (!lane_gnt[1] && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("rst_mid_gnt_seen", 32'(lane_gnt[1]), 32'd1);
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_gnt", 32'(lane_gnt), 32'd0);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    tb_clear();
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    push_byte(3, 8'hE7);
    push_byte(0, 8'h18);
    model_batch();
    wait_drain("post_rst");

    // Randomized batches with random backpressure and noise on idle lanes
    rdy_rand = 1;
    for (int b = 0; b < 8; b++) begin
      for (int l = 0; l < NL; l++) begin
        int n;
        n = int'($urandom_range(0, 3));
        for (int k = 0; k < n; k++) push_byte(l, 8'($urandom));
      end
      model_batch();
      wait_drain($sformatf("rand%0d", b));
    end
    rdy_rand = 0;
    repeat (4) @(negedge clk);
    chk("final_outstanding", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
